// File: rtl/tone_seq_dds.sv
// rtl/tone_seq_dds.sv - multi-tone DDS sequencer driving a sine ROM and an 8-bit DAC
module tone_seq_dds #(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int N_TONES = 3,
    parameter int DUR_W   = 25,
    localparam int IDX_W  = (N_TONES > 1) ? $clog2(N_TONES) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [N_TONES*PHASE_W-1:0] tune_words_i,
    input  logic [DUR_W-1:0]           duration_i,
    input  logic [1:0]                 atten_i,
    output logic [ADDR_W-1:0]          rom_addr_o,
    input  logic [DATA_W-1:0]          rom_q_i,
    output logic [DATA_W-1:0]          sample_out_o,
    output logic                       sample_valid_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [IDX_W-1:0]           tone_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_FINISH
    } state_t;

    localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W:0]   MID_X    = {2'b01, {(DATA_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_TONES - 1);

    state_t              state_q;
    logic [PHASE_W-1:0]  phase_q;
    logic [DUR_W-1:0]    cnt_q;
    logic [DUR_W-1:0]    dur_m1_q;
    logic [1:0]          atten_q;
    logic [IDX_W-1:0]    tone_idx_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                busy_q;
    logic                done_q;
    logic                vld1_q;
    logic                rest1_q;
    logic [DATA_W-1:0]   sample_q;
    logic                sample_vld_q;

    logic [PHASE_W-1:0]       tune_arr [N_TONES];
    logic [PHASE_W-1:0]       tune_cur;
    logic [PHASE_W-1:0]       phase_d;
    logic [DUR_W-1:0]         dur_m1_d;
    logic                     rest_d;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W-1:0] shifted;
    logic [DATA_W-1:0]        sample_d;

    for (genvar i = 0; i < N_TONES; i++) begin : g_tune
        assign tune_arr[i] = tune_words_i[i*PHASE_W +: PHASE_W];
    end

    always_comb begin
        tune_cur = tune_arr[tone_idx_q];
        phase_d  = phase_q + tune_cur;
        dur_m1_d = (duration_i == '0) ? '0 : duration_i - DUR_W'(1);
        rest_d   = (tune_cur == '0);
        // Recentre the offset-binary ROM word so the shift attenuates around midscale
        diff     = $signed({1'b0, rom_q_i} - MID_X);
        shifted  = DATA_W'(diff >>> atten_q);
        sample_d = MID;
        if (vld1_q && !rest1_q) begin
            sample_d = MID + $unsigned(shifted);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            cnt_q        <= '0;
            dur_m1_q     <= '0;
            atten_q      <= '0;
            tone_idx_q   <= '0;
            rom_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vld1_q       <= 1'b0;
            rest1_q      <= 1'b0;
            sample_q     <= MID;
            sample_vld_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            vld1_q       <= busy_q;
            rest1_q      <= busy_q && rest_d;
            sample_vld_q <= vld1_q;
            sample_q     <= sample_d;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_PLAY;
                        phase_q    <= '0;
                        rom_addr_q <= '0;
                        tone_idx_q <= '0;
                        cnt_q      <= dur_m1_d;
                        dur_m1_q   <= dur_m1_d;
                        atten_q    <= atten_i;
                        busy_q     <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (cnt_q == '0) begin
                        if (tone_idx_q == LAST_IDX) begin
                            state_q <= S_FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // Next tone starts on the following cycle from phase 0
                            tone_idx_q <= tone_idx_q + IDX_W'(1);
                            phase_q    <= '0;
                            rom_addr_q <= '0;
                            cnt_q      <= dur_m1_q;
                        end
                    end else begin
                        cnt_q      <= cnt_q - DUR_W'(1);
                        phase_q    <= phase_d;
                        rom_addr_q <= phase_d[PHASE_W-1 -: ADDR_W];
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr_o     = rom_addr_q;
    assign sample_out_o   = sample_q;
    assign sample_valid_o = sample_vld_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign tone_idx_o     = tone_idx_q;

endmodule

// File: tb/tb_tone_seq_dds.sv
// tb/tb_tone_seq_dds.sv - randomized self-checking bench for tone_seq_dds
module tb_tone_seq_dds;

    localparam int PW   = 24;
    localparam int AW   = 10;
    localparam int DW   = 8;
    localparam int NT   = 3;
    localparam int DURW = 25;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NT*PW-1:0]  tune_words;
    logic [DURW-1:0]   duration;
    logic [1:0]        atten;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_q;
    logic [DW-1:0]     sample_out;
    logic              sample_valid;
    logic              busy;
    logic              done;
    logic [1:0]        tone_idx;

    int unsigned tunes [NT];
    logic [7:0]  rom_mem [1024];
    int          checks   = 0;
    int          failures = 0;

    tone_seq_dds dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .tune_words_i   (tune_words),
        .duration_i     (duration),
        .atten_i        (atten),
        .rom_addr_o     (rom_addr),
        .rom_q_i        (rom_q),
        .sample_out_o   (sample_out),
        .sample_valid_o (sample_valid),
        .busy_o         (busy),
        .done_o         (done),
        .tone_idx_o     (tone_idx)
    );

    always #20 clk = ~clk;

    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Address of PLAY cycle c: k-th cycle of its tone sees phase k*tune
    function automatic int exp_addr(input int c, input int deff);
        int          tone = c / deff;
        int unsigned k    = c % deff;
        int unsigned p    = k * tunes[tone];
        return int'((p >> 14) & 32'd1023);
    endfunction

    function automatic int exp_sample(input int c, input int deff, input int at);
        int tone = c / deff;
        int d;
        if (tunes[tone] == 0) return 128;
        d = int'(rom_mem[exp_addr(c, deff)]) - 128;
        return 128 + (d >>> at);
    endfunction

    task automatic set_cfg(input int unsigned t0, input int unsigned t1, input int unsigned t2,
                           input int dur, input int at);
        tunes[0] = t0 & 32'hFFFFFF;
        tunes[1] = t1 & 32'hFFFFFF;
        tunes[2] = t2 & 32'hFFFFFF;
        for (int i = 0; i < NT; i++) tune_words[i*PW +: PW] = tunes[i][PW-1:0];
        duration = DURW'(dur);
        atten    = 2'(at);
    endtask

    task automatic fill_rom(input int mode, input int val);
        for (int a = 0; a < 1024; a++) begin
            if (mode == 0)      rom_mem[a] = 8'(a);
            else if (mode == 1) rom_mem[a] = 8'(val);
            else                rom_mem[a] = 8'($urandom);
        end
    endtask

    // Checks PLAY cycles 0..L-1, the FINISH cycle L and the IDLE cycle L+1
    task automatic run(input bit prestarted, input bit hold, input int pulse_at, input string name);
        int deff = (duration == '0) ? 1 : int'(duration);
        int L    = NT * deff;
        int at   = int'(atten);
        bit vexp;
        if (!prestarted) start = 1'b1;
        for (int c = 0; c <= L + 1; c++) begin
            @(negedge clk);
            vexp = (c >= 2) && (c < L + 2);
            check($sformatf("%s c%0d busy", name, c), busy, (c < L));
            check($sformatf("%s c%0d done", name, c), done, (c == L));
            if (c < L) begin
                check($sformatf("%s c%0d tone_idx", name, c), tone_idx, c / deff);
                check($sformatf("%s c%0d rom_addr", name, c), rom_addr, exp_addr(c, deff));
            end
            check($sformatf("%s c%0d valid", name, c), sample_valid, vexp);
            check($sformatf("%s c%0d sample", name, c), sample_out,
                  vexp ? exp_sample(c - 2, deff, at) : 128);
            start = hold || (c + 1 == pulse_at);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, " busy"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " valid"}, sample_valid, 0);
        check({name, " sample"}, sample_out, 128);
        check({name, " rom_addr"}, rom_addr, 0);
        check({name, " tone_idx"}, tone_idx, 0);
    endtask

    function automatic int unsigned rand_tune();
        if ($urandom_range(0, 3) == 0) return 0;
        return $urandom & 32'hFFFFFF;
    endfunction

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_cfg(0, 0, 0, 1, 0);
        fill_rom(0, 0);
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        set_cfg(32'h4000, 32'h8000, 32'h2000, 8, 0);
        run(0, 0, 0, "step");

        fill_rom(2, 0);
        set_cfg(32'h12345, 32'h0ABCDE, 32'h3F0000, 5, 2);
        run(0, 0, 3, "seq5");

        set_cfg(32'h100000, 32'h200000, 32'h300000, 0, 1);
        run(0, 0, 0, "dur0");

        set_cfg(32'h4000, 32'h8000, 32'hC000, 4, 1);
        fill_rom(1, 255);
        run(0, 0, 0, "att1_255");
        fill_rom(1, 0);
        run(0, 0, 0, "att1_0");
        set_cfg(32'h4000, 32'h8000, 32'hC000, 4, 3);
        fill_rom(1, 255);
        run(0, 0, 0, "att3_255");
        fill_rom(1, 0);
        run(0, 0, 0, "att3_0");

        fill_rom(0, 0);
        set_cfg(32'h1000000 - 32'h4000, 0, 32'h4000, 6, 0);
        run(0, 0, 3 * 6 + 1, "rest_wrap");

        fill_rom(2, 0);
        set_cfg(rand_tune(), rand_tune(), rand_tune(), 4, 0);
        run(0, 1, 0, "hold1");
        run(1, 0, 0, "hold2");

        set_cfg(32'h4000, 32'h8000, 32'h2000, 6, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        check("midrst done_held", done, 0);
        rst = 1'b0;
        @(negedge clk);
        run(0, 0, 0, "after_rst");

        for (int r = 0; r < 12; r++) begin
            fill_rom(2, 0);
            set_cfg(rand_tune(), rand_tune(), rand_tune(),
                    int'($urandom_range(0, 10)), int'($urandom_range(0, 3)));
            run(0, 0, int'($urandom_range(0, 8)), $sformatf("rand%0d", r));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
